imm_decode_pipe: RTL and testbench

Registered, parametrised immediate decoder for the decode stage. Takes a raw 32-bit RISC-V instruction over a valid/ready handshake and derives the immediate format from the opcode. Emits the sign-extended immediate at XLEN width, with a format tag, through a 2-entry skid buffer, so full throughput is kept under backpressure. Sits between the fetch/instruction buffer and the register-read stage.

---
 rtl/imm_decode_pipe.sv | 174 +++++++++++++++++
 tb/tb_imm_decode_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imm_decode_pipe.sv
// imm_decode_pipe: opcode-driven immediate decode behind a 2-entry skid buffer.
// Optional macro IMM_ILLEGAL_DETECT_EN flags opcodes with no immediate format.
module imm_decode_pipe #(
    parameter int XLEN         = 32,
    parameter bit OPIMM32_EN_P = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] imm_ext,
    output logic [2:0]      imm_type,
    output logic            illegal
);

    typedef enum logic [2:0] {
        FMT_I    = 3'd0,
        FMT_S    = 3'd1,
        FMT_B    = 3'd2,
        FMT_U    = 3'd3,
        FMT_J    = 3'd4,
        FMT_NONE = 3'd7
    } fmt_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      typ;
        logic            ill;
    } entry_t;

    localparam entry_t RST_ENTRY = '{imm: '0, typ: FMT_NONE, ill: 1'b0};
    localparam bit OPIMM32_ON = OPIMM32_EN_P && (XLEN == 64);

    logic [6:0]  opcode;
    logic        is_i;
    logic        is_s;
    logic        is_b;
    logic        is_u;
    logic        is_j;
    logic [31:0] dec_imm32;
    fmt_e        dec_type;
    logic        dec_ill;
    entry_t      dec;

    assign opcode = instr[6:0];

    assign is_i = (opcode == 7'b0000011)
                || (opcode == 7'b0010011)
                || (opcode == 7'b1100111)
                || (OPIMM32_ON && (opcode == 7'b0011011));
    assign is_s = (opcode == 7'b0100011);
    assign is_b = (opcode == 7'b1100011);
    assign is_u = (opcode == 7'b0110111)
                || (opcode == 7'b0010111);
    assign is_j = (opcode == 7'b1101111);

    always_comb begin
        dec_imm32 = '0;
        dec_type  = FMT_NONE;
        dec_ill   = 1'b0;
        unique case (1'b1)
            is_i: begin
                dec_type  = FMT_I;
                dec_imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            is_s: begin
                dec_type  = FMT_S;
                dec_imm32 = {{20{instr[31]}}, instr[31:25],
                             instr[11:7]};
            end
            is_b: begin
                dec_type  = FMT_B;
                dec_imm32 = {{19{instr[31]}}, instr[31], instr[7],
                             instr[30:25], instr[11:8], 1'b0};
            end
            is_u: begin
                dec_type  = FMT_U;
                dec_imm32 = {instr[31:12], 12'b0};
            end
            is_j: begin
                dec_type  = FMT_J;
                dec_imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
            end
            default: begin
`ifdef IMM_ILLEGAL_DETECT_EN
                dec_type  = FMT_NONE;
                dec_imm32 = '0;
                dec_ill   = 1'b1;
`else
                // No detection: fall back to the I-form extraction.
                dec_type  = FMT_I;
                dec_imm32 = {{20{instr[31]}}, instr[31:20]};
`endif
            end
        endcase
    end

    assign dec.imm = XLEN'($signed(dec_imm32));
    assign dec.typ = dec_type;
    assign dec.ill = dec_ill;

    state_e state_q;
    entry_t main_q;
    entry_t skid_q;
    logic   in_hs;
    logic   out_hs;

    assign in_hs  = in_valid && in_ready;
    assign out_hs = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            main_q    <= RST_ENTRY;
            skid_q    <= RST_ENTRY;
        end else if (flush) begin
            state_q   <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_hs) begin
                        main_q    <= dec;
                        state_q   <= ONE;
                        out_valid <= 1'b1;
                    end
                end
                ONE: begin
                    if (in_hs && !out_hs) begin
                        skid_q   <= dec;
                        state_q  <= FULL;
                        in_ready <= 1'b0;
                    end else if (in_hs) begin
                        main_q <= dec;
                    end else if (out_hs) begin
                        state_q   <= EMPTY;
                        out_valid <= 1'b0;
                    end
                end
                FULL: begin
                    if (out_hs) begin
                        main_q   <= skid_q;
                        state_q  <= ONE;
                        in_ready <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign imm_ext  = main_q.imm;
    assign imm_type = main_q.typ;
    assign illegal  = main_q.ill;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Bench for imm_decode_pipe: XLEN=32 and XLEN=64/OPIMM32 instances share stimulus
// and are checked every cycle against a queue model of decoded instructions.
module tb_imm_decode_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] instr = '0;
    logic        out_ready = 1'b0;

    logic        in_ready32;
    logic        out_valid32;
    logic [31:0] imm_ext32;
    logic [2:0]  imm_type32;
    logic        illegal32;

    logic        in_ready64;
    logic        out_valid64;
    logic [63:0] imm_ext64;
    logic [2:0]  imm_type64;
    logic        illegal64;

    int checks = 0;
    int failures = 0;

`ifdef IMM_ILLEGAL_DETECT_EN
    localparam bit DET = 1'b1;
`else
    localparam bit DET = 1'b0;
`endif

    always #5 clk = ~clk;

    imm_decode_pipe #(.XLEN(32), .OPIMM32_EN_P(1'b0)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .instr(instr),
        .out_valid(out_valid32), .out_ready(out_ready),
        .imm_ext(imm_ext32), .imm_type(imm_type32), .illegal(illegal32)
    );

    imm_decode_pipe #(.XLEN(64), .OPIMM32_EN_P(1'b1)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64), .instr(instr),
        .out_valid(out_valid64), .out_ready(out_ready),
        .imm_ext(imm_ext64), .imm_type(imm_type64), .illegal(illegal64)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic longint sext(input longint v, input int bits);
        longint half;
        half = longint'(1) << (bits - 1);
        return (v >= half) ? v - (half * 2) : v;
    endfunction

    function automatic logic [2:0] exp_type(input logic [31:0] ins,
                                            input bit op32);
        case (ins[6:0])
            7'h03, 7'h13, 7'h67: return 3'd0;
            7'h23:               return 3'd1;
            7'h63:               return 3'd2;
            7'h37, 7'h17:        return 3'd3;
            7'h6F:               return 3'd4;
            7'h1B:               return op32 ? 3'd0 : (DET ? 3'd7 : 3'd0);
            default:             return DET ? 3'd7 : 3'd0;
        endcase
    endfunction

    function automatic longint exp_imm(input logic [31:0] ins,
                                       input bit op32);
        longint v;
        case (exp_type(ins, op32))
            3'd0: v = sext(longint'(ins[31:20]), 12);
            3'd1: v = sext(longint'(ins[31:25]) * 32
                           + longint'(ins[11:7]), 12);
            3'd2: v = sext(longint'(ins[31]) * 4096
                           + longint'(ins[7]) * 2048
                           + longint'(ins[30:25]) * 32
                           + longint'(ins[11:8]) * 2, 13);
            3'd3: v = sext(longint'(ins[31:12]), 20) * 4096;
            3'd4: v = sext(longint'(ins[31]) * (longint'(1) << 20)
                           + longint'(ins[19:12]) * 4096
                           + longint'(ins[20]) * 2048
                           + longint'(ins[30:21]) * 2, 21);
            default: v = 0;
        endcase
        return v;
    endfunction

    logic [31:0] q[$];
    bit started = 1'b0;

    initial forever begin
        bit ihs;
        bit ohs;
        @(posedge clk);
        ihs = in_valid && (q.size() < 2);
        ohs = out_ready && (q.size() > 0);
        if (rst || flush) begin
            q.delete();
        end else begin
            if (ohs) void'(q.pop_front());
            if (ihs) q.push_back(instr);
        end
        started = 1'b1;
    end

    initial forever begin
        logic [31:0] ins;
        longint e64;
        longint e32;
        @(negedge clk);
        if (started) begin
            chk("valid32", {63'd0, out_valid32}, {63'd0, q.size() > 0});
            chk("ready32", {63'd0, in_ready32}, {63'd0, q.size() < 2});
            chk("valid64", {63'd0, out_valid64}, {63'd0, q.size() > 0});
            chk("ready64", {63'd0, in_ready64}, {63'd0, q.size() < 2});
            if (q.size() > 0) begin
                ins = q[0];
                e32 = exp_imm(ins, 1'b0);
                e64 = exp_imm(ins, 1'b1);
                chk("imm32", {32'd0, imm_ext32}, {32'd0, e32[31:0]});
                chk("type32", {61'd0, imm_type32}, {61'd0, exp_type(ins, 1'b0)});
                chk("ill32", {63'd0, illegal32},
                    {63'd0, DET && exp_type(ins, 1'b0) == 3'd7});
                chk("imm64", imm_ext64, e64);
                chk("type64", {61'd0, imm_type64}, {61'd0, exp_type(ins, 1'b1)});
                chk("ill64", {63'd0, illegal64},
                    {63'd0, DET && exp_type(ins, 1'b1) == 3'd7});
            end
        end
    end

    task automatic step(input logic v, input logic [31:0] ins,
                        input logic ordy, input logic fl, input logic r);
        in_valid  = v;
        instr     = ins;
        out_ready = ordy;
        flush     = fl;
        rst       = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        longint m;
        m = exp_imm(32'hFFF00093, 1'b0);
        chk("pin_i", m, 64'hFFFFFFFFFFFFFFFF);
        m = exp_imm(32'h0020A423, 1'b0);
        chk("pin_s", m, 64'h8);
        m = exp_imm(32'hFE000EE3, 1'b0);
        chk("pin_b", m, 64'hFFFFFFFFFFFFFFFC);
        m = exp_imm(32'h123450B7, 1'b0);
        chk("pin_u", m, 64'h12345000);
        m = exp_imm(32'h0010006F, 1'b0);
        chk("pin_j", m, 64'h800);
        m = exp_imm(32'h800000B7, 1'b1);
        chk("pin_u64", m, 64'hFFFFFFFF80000000);

        step(1, 32'hFFF00093, 1, 0, 1);
        step(1, 32'hFFF00093, 1, 0, 1);
        chk("rst_valid", {63'd0, out_valid32}, 64'd0);
        chk("rst_type", {61'd0, imm_type32}, 64'd7);
        chk("rst_imm", {32'd0, imm_ext32}, 64'd0);
        chk("rst_ill", {63'd0, illegal32}, 64'd0);
        chk("rst_ready", {63'd0, in_ready32}, 64'd1);

        step(1, 32'hFFF00093, 1, 0, 0);
        chk("lat_valid", {63'd0, out_valid32}, 64'd1);
        chk("lat_imm", {32'd0, imm_ext32}, 64'hFFFFFFFF);
        step(1, 32'h0020A423, 1, 0, 0);
        chk("s_type", {61'd0, imm_type32}, 64'd1);
        step(1, 32'hFE000EE3, 1, 0, 0);
        chk("b_imm", {32'd0, imm_ext32}, 64'hFFFFFFFC);
        step(1, 32'h123450B7, 1, 0, 0);
        step(1, 32'h0010006F, 1, 0, 0);
        chk("j_imm", {32'd0, imm_ext32}, 64'h800);
        step(0, 32'h0, 1, 0, 0);
        step(0, 32'h0, 1, 0, 0);

        step(1, 32'h00100093, 0, 0, 0);
        step(1, 32'h0020A423, 0, 0, 0);
        chk("bp_ready_low", {63'd0, in_ready32}, 64'd0);
        step(1, 32'hFFF00093, 0, 0, 0);
        chk("bp_hold_imm", {32'd0, imm_ext32}, 64'd1);
        step(1, 32'hFFF00093, 1, 0, 0);
        chk("bp_second", {32'd0, imm_ext32}, 64'd8);
        step(1, 32'hFFF00093, 1, 0, 0);
        chk("bp_third", {32'd0, imm_ext32}, 64'hFFFFFFFF);
        step(0, 32'h0, 1, 0, 0);
        chk("bp_drain", {63'd0, out_valid32}, 64'd0);

        step(1, 32'h00500113, 0, 0, 0);
        step(1, 32'h00A00193, 0, 0, 0);
        step(1, 32'h123450B7, 0, 1, 0);
        chk("fl_valid", {63'd0, out_valid32}, 64'd0);
        chk("fl_ready", {63'd0, in_ready32}, 64'd1);
        step(0, 32'h0, 1, 0, 0);
        chk("fl_dropped", {63'd0, out_valid64}, 64'd0);

        step(1, 32'h00000033, 1, 0, 0);
        chk("op_type", {61'd0, imm_type32}, DET ? 64'd7 : 64'd0);
        chk("op_ill", {63'd0, illegal32}, {63'd0, DET});
        chk("op_imm", {32'd0, imm_ext32}, 64'd0);
        step(1, 32'hFFF0001B, 1, 0, 0);
        chk("w_type64", {61'd0, imm_type64}, 64'd0);
        chk("w_imm64", imm_ext64, 64'hFFFFFFFFFFFFFFFF);
        step(1, 32'h800000B7, 1, 0, 0);
        chk("u64_imm", imm_ext64, 64'hFFFFFFFF80000000);
        chk("u64_type", {61'd0, imm_type64}, 64'd3);
        step(1, 32'hFFF00093, 1, 0, 0);
        chk("i64_imm", imm_ext64, 64'hFFFFFFFFFFFFFFFF);
        step(0, 32'h0, 1, 0, 0);

        step(1, 32'h00100093, 0, 0, 0);
        step(1, 32'h0020A423, 0, 0, 0);
        step(1, 32'hFE000EE3, 1, 0, 1);
        chk("mr_valid", {63'd0, out_valid32}, 64'd0);
        chk("mr_type", {61'd0, imm_type32}, 64'd7);
        chk("mr_ready", {63'd0, in_ready32}, 64'd1);
        chk("mr_imm64", imm_ext64, 64'd0);
        step(0, 32'h0, 1, 0, 0);
        chk("mr_after", {63'd0, out_valid32}, 64'd0);
        step(0, 32'h0, 1, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
